uart_rx_fifo: RTL

Byte buffer placed directly downstream of the UART receiver and upstream of the display and LED consumers. It captures each received byte on the receiver's one-cycle `rx_done` strobe, so bytes arriving back-to-back at 115200 bps are not lost while a slower consumer drains them. It provides occupancy status and a sticky overflow flag.

---
 rtl/uart_rx_fifo_if.sv | 27 ++
 rtl/uart_rx_fifo.sv | 114 +++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bundle of the write/read/status signals between the UART receiver side,
// the consumer side and the rx byte FIFO.
interface uart_rx_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic [DATA_W-1:0]   wr_data;
    logic                wr_en;
    logic                rd_en;
    logic                clr_ovf;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;

    modport master (
        output wr_data, wr_en, rd_en, clr_ovf,
        input  rd_data, rd_valid, empty, full, count, overflow
    );

    modport slave (
        input  wr_data, wr_en, rd_en, clr_ovf,
        output rd_data, rd_valid, empty, full, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between the UART receiver and slower consumers. Captures one byte
// per rx_done strobe, reports occupancy and a sticky overflow flag.
// Optional macro UART_RX_FIFO_FWFT_EN selects first-word-fall-through reads;
// without it, reads are registered (data one cycle after the accepted rd_en).
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = '0;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  empty_q;
    logic                  full_q;
    logic                  overflow_q;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  wr_drop;

    // Accept decisions and next occupancy; a read frees the slot a full-FIFO write needs.
    always_comb begin
        rd_accept  = bus.rd_en && !empty_q;
        wr_accept  = bus.wr_en && (!full_q || rd_accept);
        wr_drop    = bus.wr_en && !wr_accept;
        count_next = count_q;
        if (wr_accept && !rd_accept) begin
            count_next = count_q + CNT_ONE;
        end else if (rd_accept && !wr_accept) begin
            count_next = count_q - CNT_ONE;
        end
    end

    // Storage array is not reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers, occupancy and registered empty/full flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_q <= count_next;
            empty_q <= (count_next == CNT_ZERO);
            full_q  <= (count_next == CNT_FULL);
        end
    end

    // Sticky overflow: a dropped byte in the same cycle as clr_ovf keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (wr_drop) begin
            overflow_q <= 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_q <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_FWFT_EN
    // Head of queue is presented combinationally; rd_en only acknowledges it.
    always_comb begin
        bus.rd_data  = empty_q ? '0 : mem[rd_ptr];
        bus.rd_valid = !empty_q;
    end
`else
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // Registered read: popped byte appears after the accepting edge and holds until the next pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= mem[rd_ptr];
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule
